// File: rtl/mux_arbitro_rr_if.sv
// Handshake bundle between two requesters, the round-robin mux, and its downstream consumer.
// The slave modport is the arbiter's view and the master modport is the environment's view.
interface mux_arbitro_rr_if #(
   parameter int DATA_WIDTH = 4
);
   logic [DATA_WIDTH-1:0] data_0;
   logic                  valid_0;
   logic                  ready_0;
   logic [DATA_WIDTH-1:0] data_1;
   logic                  valid_1;
   logic                  ready_1;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  valid_out;
   logic                  ready_out;
   logic                  sel_out;

   modport slave (
      input  data_0, valid_0, data_1, valid_1, ready_out,
      output ready_0, ready_1, data_out, valid_out, sel_out
   );

   modport master (
      output data_0, valid_0, data_1, valid_1, ready_out,
      input  ready_0, ready_1, data_out, valid_out, sel_out
   );
endinterface

// File: rtl/mux_arbitro_rr.sv
// Two-channel round-robin scheduler with bounded bursts feeding a one-entry registered output stage.
// Optional grant statistics counters (cnt_0/cnt_1) are compiled in with MUX_ARB_STATS_EN.
module mux_arbitro_rr #(
   parameter int DATA_WIDTH = 4,
   parameter int MAX_BURST  = 4,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
`ifdef MUX_ARB_STATS_EN
   output logic [CNT_WIDTH-1:0] cnt_0,
   output logic [CNT_WIDTH-1:0] cnt_1,
`endif
   mux_arbitro_rr_if.slave      bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   localparam logic [3:0] MAX_B = 4'(MAX_BURST);

   state_t                state_q, state_d;
   logic [3:0]            burst_q, burst_d;
   logic                  last_q, last_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  sel_q, sel_d;

   logic load_s;
   logic grant_v_s;
   logic grant_ch_s;

   // A new word may enter only when the output stage is empty or being drained.
   assign load_s = bus.ready_out | ~valid_q;

   // Grant selection: burst limit only matters when both channels contend.
   always_comb begin
      grant_v_s  = 1'b0;
      grant_ch_s = 1'b0;
      if (!reset && load_s) begin
         if (bus.valid_0 && bus.valid_1) begin
            grant_v_s = 1'b1;
            case (state_q)
               IDLE:    grant_ch_s = ~last_q;
               OWN0:    grant_ch_s = (burst_q < MAX_B) ? 1'b0 : 1'b1;
               OWN1:    grant_ch_s = (burst_q < MAX_B) ? 1'b1 : 1'b0;
               default: grant_ch_s = ~last_q;
            endcase
         end else if (bus.valid_0) begin
            grant_v_s  = 1'b1;
            grant_ch_s = 1'b0;
         end else if (bus.valid_1) begin
            grant_v_s  = 1'b1;
            grant_ch_s = 1'b1;
         end else begin
            grant_v_s  = 1'b0;
            grant_ch_s = 1'b0;
         end
      end else begin
         grant_v_s  = 1'b0;
         grant_ch_s = 1'b0;
      end
   end

   assign bus.ready_0 = grant_v_s & ~grant_ch_s;
   assign bus.ready_1 = grant_v_s &  grant_ch_s;

   // Next-state for FSM, burst tracking and output stage.
   always_comb begin
      state_d = state_q;
      burst_d = burst_q;
      last_d  = last_q;
      data_d  = data_q;
      valid_d = valid_q;
      sel_d   = sel_q;
      if (grant_v_s) begin
         data_d  = grant_ch_s ? bus.data_1 : bus.data_0;
         sel_d   = grant_ch_s;
         valid_d = 1'b1;
         last_d  = grant_ch_s;
         state_d = grant_ch_s ? OWN1 : OWN0;
         if (state_q == (grant_ch_s ? OWN1 : OWN0)) begin
            burst_d = (burst_q < MAX_B) ? (burst_q + 4'd1) : burst_q;
         end else begin
            burst_d = 4'd1;
         end
      end else if (load_s) begin
         valid_d = 1'b0;
         state_d = IDLE;
         burst_d = 4'd0;
      end else begin
         valid_d = valid_q;
      end
   end

   // State register with synchronous reset; last_owner resets to 1 so channel 0 wins first.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         burst_q <= 4'd0;
         last_q  <= 1'b1;
         data_q  <= '0;
         valid_q <= 1'b0;
         sel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         burst_q <= burst_d;
         last_q  <= last_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         sel_q   <= sel_d;
      end
   end

   assign bus.data_out  = data_q;
   assign bus.valid_out = valid_q;
   assign bus.sel_out   = sel_q;

`ifdef MUX_ARB_STATS_EN
   logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
   logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;

   // Saturating per-channel transfer counters.
   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (bus.ready_0 && (cnt0_q != {CNT_WIDTH{1'b1}})) begin
         cnt0_d = cnt0_q + CNT_WIDTH'(1);
      end else begin
         cnt0_d = cnt0_q;
      end
      if (bus.ready_1 && (cnt1_q != {CNT_WIDTH{1'b1}})) begin
         cnt1_d = cnt1_q + CNT_WIDTH'(1);
      end else begin
         cnt1_d = cnt1_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign cnt_0 = cnt0_q;
   assign cnt_1 = cnt1_q;
`endif

endmodule

// File: tb/tb_mux_arbitro_rr.sv
// Directed self-checking bench for mux_arbitro_rr: reset, single stream, contention, backpressure,
// reset mid-burst and burst saturation, with a queue of expected output words.
module tb_mux_arbitro_rr;
   localparam int DW = 4;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mux_arbitro_rr_if #(.DATA_WIDTH(DW)) bus ();

`ifdef MUX_ARB_STATS_EN
   logic [CW-1:0] cnt_0, cnt_1;
   logic [CW-1:0] exp_c0, exp_c1;
`endif

   mux_arbitro_rr #(.DATA_WIDTH(DW), .MAX_BURST(4), .CNT_WIDTH(CW)) dut (
      .clk   (clk),
      .reset (reset),
`ifdef MUX_ARB_STATS_EN
      .cnt_0 (cnt_0),
      .cnt_1 (cnt_1),
`endif
      .bus   (bus.slave)
   );

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [4:0] sb_q[$];
   logic [4:0] last_word;
   logic [4:0] exp_word;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One reset cycle with arbitrary requests present; no ready may be raised.
   task automatic rst_cycle(input logic v0, input logic v1);
      @(negedge clk);
      reset = 1'b1;
      bus.valid_0 = v0;  bus.data_0 = 4'h7;
      bus.valid_1 = v1;  bus.data_1 = 4'h8;
      bus.ready_out = 1'b1;
      #1;
      chk("rst_ready_0", 32'(bus.ready_0), 32'd0);
      chk("rst_ready_1", 32'(bus.ready_1), 32'd0);
      @(posedge clk); #1;
      chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
      chk("rst_data_out", 32'(bus.data_out), 32'd0);
      chk("rst_sel_out", 32'(bus.sel_out), 32'd0);
      last_word = 5'd0;
      sb_q.delete();
`ifdef MUX_ARB_STATS_EN
      exp_c0 = '0;
      exp_c1 = '0;
      chk("rst_cnt_0", 32'(cnt_0), 32'd0);
      chk("rst_cnt_1", 32'(cnt_1), 32'd0);
`endif
   endtask

   // Drive one cycle, check grants, then check the output stage after the edge.
   task automatic cycle(input logic v0, input logic [3:0] d0, input logic v1, input logic [3:0] d1,
                        input logic ro, input logic er0, input logic er1, input logic evo);
      @(negedge clk);
      reset = 1'b0;
      bus.valid_0 = v0;  bus.data_0 = d0;
      bus.valid_1 = v1;  bus.data_1 = d1;
      bus.ready_out = ro;
      #1;
      chk("ready_0", 32'(bus.ready_0), 32'(er0));
      chk("ready_1", 32'(bus.ready_1), 32'(er1));
      if (er0) begin
         sb_q.push_back({1'b0, d0});
`ifdef MUX_ARB_STATS_EN
         if (exp_c0 != {CW{1'b1}}) exp_c0 = exp_c0 + 8'd1;
`endif
      end else if (er1) begin
         sb_q.push_back({1'b1, d1});
`ifdef MUX_ARB_STATS_EN
         if (exp_c1 != {CW{1'b1}}) exp_c1 = exp_c1 + 8'd1;
`endif
      end
      @(posedge clk); #1;
      if (er0 || er1) begin
         chk("valid_out_load", 32'(bus.valid_out), 32'd1);
         if (sb_q.size() > 0) begin
            exp_word = sb_q.pop_front();
            chk("sel_data_out", 32'({bus.sel_out, bus.data_out}), 32'(exp_word));
            last_word = exp_word;
         end else begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
         end
      end else begin
         chk("valid_out_hold", 32'(bus.valid_out), 32'(evo));
         chk("sel_data_hold", 32'({bus.sel_out, bus.data_out}), 32'(last_word));
      end
   endtask

   initial begin
      logic [8:0] pat9;
      logic [4:0] pat5;
      bus.valid_0 = 1'b0; bus.data_0 = 4'h0;
      bus.valid_1 = 1'b0; bus.data_1 = 4'h0;
      bus.ready_out = 1'b0;
      last_word = 5'd0;
`ifdef MUX_ARB_STATS_EN
      exp_c0 = '0;
      exp_c1 = '0;
`endif

      // Two-cycle reset with requests present
      rst_cycle(1'b1, 1'b1);
      rst_cycle(1'b0, 1'b0);
      cycle(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Single channel-1 stream
      cycle(1'b0, 4'h0, 1'b1, 4'h3, 1'b1, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 4'h0, 1'b1, 4'h4, 1'b1, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 4'h0, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Contention: runs of four, channel 0 first
      pat9 = 9'b011110000;
      for (int i = 0; i < 9; i++)
         cycle(1'b1, 4'hA, 1'b1, 4'h5, 1'b1, ~pat9[i], pat9[i], 1'b1);

      // Backpressure: three stalled cycles, then load while draining
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 4'hA, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 4'hB, 1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Reset after two channel-0 grants restarts the burst
      rst_cycle(1'b0, 1'b0);
      cycle(1'b1, 4'h1, 1'b1, 4'h2, 1'b1, 1'b1, 1'b0, 1'b1);
      cycle(1'b1, 4'h1, 1'b1, 4'h2, 1'b1, 1'b1, 1'b0, 1'b1);
      rst_cycle(1'b1, 1'b1);
      pat5 = 5'b10000;
      for (int i = 0; i < 5; i++)
         cycle(1'b1, 4'hC, 1'b1, 4'hD, 1'b1, ~pat5[i], pat5[i], 1'b1);

      // Lone channel 0 keeps its grant past the burst limit, then yields at once
      for (int i = 0; i < 6; i++)
         cycle(1'b1, 4'(i), 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1);
      cycle(1'b1, 4'h9, 1'b1, 4'hE, 1'b1, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef MUX_ARB_STATS_EN
      chk("cnt_0", 32'(cnt_0), 32'(exp_c0));
      chk("cnt_1", 32'(cnt_1), 32'(exp_c1));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
